kbd_led_seq: RTL and testbench

KBD_LED_SEQ -- requirements
Module: kbd_led_seq

---
 rtl/kbd_led_seq.sv | 153 +++++++++++++++
 tb/tb_kbd_led_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_led_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : kbd_led_seq                                            |
// | Description : Sends the keyboard "set LEDs" command (0xED) followed  |
// |               by the LED argument byte whenever the requested LED    |
// |               state changes. Each byte waits for an ACK (0xFA),      |
// |               resends on RESEND (0xFE) or reply timeout, and aborts  |
// |               with a sticky error after MAX_RETRY resends.           |
// | Options     : define KBD_LED_INIT_SEND_EN to force one LED update    |
// |               sequence after every reset.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module kbd_led_seq #(
  parameter int ACK_TIMEOUT = 30000,
  parameter int MAX_RETRY   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] leds,
  input  logic       tx_busy,
  output logic       tx_wren,
  output logic [7:0] tx_d,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       busy,
  output logic       error
);

  localparam logic [15:0] ACK_LOAD     = 16'(ACK_TIMEOUT);
  localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRY);
  localparam logic [7:0]  CMD_SET_LEDS = 8'hED;
  localparam logic [7:0]  KBD_ACK      = 8'hFA;
  localparam logic [7:0]  KBD_RESEND   = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_TXS = 3'd2,
    S_WAIT_TXE = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_t;

  state_t      state;
  logic        phase;      // 0: command byte, 1: argument byte
  logic [2:0]  retry;
  logic [15:0] counter;
  logic [2:0]  cur;
  logic [2:0]  last_sent;
  logic        init_flag;

  logic start;
  logic got_ack;
  logic got_resend;
  logic expired;

  assign start      = (leds != last_sent) || init_flag;
  assign got_ack    = rx_valid && (rx_data == KBD_ACK);
  assign got_resend = rx_valid && (rx_data == KBD_RESEND);
  assign expired    = (counter == 16'd0);

  // The send strobe is only ever presented while in SEND with the transmitter free.
  assign tx_wren = (state == S_SEND) && !tx_busy;
  assign busy    = (state != S_IDLE);

`ifdef KBD_LED_INIT_SEND_EN
  // Init request survives until the first sequence after reset starts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_flag <= 1'b1;
    end else if (state == S_IDLE) begin
      init_flag <= 1'b0;
    end
  end
`else
  assign init_flag = 1'b0;
`endif

  // Sequencer: command byte, argument byte, each with ACK wait and resend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      tx_d      <= 8'h00;
      error     <= 1'b0;
      last_sent <= 3'b000;
      retry     <= 3'd0;
      counter   <= 16'd0;
      phase     <= 1'b0;
      cur       <= 3'b000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur   <= leds;
            error <= 1'b0;
            phase <= 1'b0;
            retry <= 3'd0;
            tx_d  <= CMD_SET_LEDS;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            state <= S_WAIT_TXS;
          end
        end
        S_WAIT_TXS: begin
          if (tx_busy) begin
            state <= S_WAIT_TXE;
          end
        end
        S_WAIT_TXE: begin
          if (!tx_busy) begin
            counter <= ACK_LOAD;
            state   <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          // A valid reply wins over a timeout landing on the same cycle.
          if (got_ack) begin
            if (!phase) begin
              phase <= 1'b1;
              retry <= 3'd0;
              tx_d  <= {5'b00000, cur};
              state <= S_SEND;
            end else begin
              last_sent <= cur;
              state     <= S_IDLE;
            end
          end else if (got_resend || expired) begin
            if (retry < RETRY_LIMIT) begin
              retry <= retry + 3'd1;
              state <= S_SEND;
            end else begin
              // Give up and record the value anyway so a dead keyboard
              // does not cause an endless retry loop.
              error     <= 1'b1;
              last_sent <= cur;
              state     <= S_IDLE;
            end
          end else begin
            counter <= counter - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_led_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_kbd_led_seq                                         |
// | Description : Scoreboard bench for kbd_led_seq with a transmitter /  |
// |               keyboard model and a protocol-level reference model.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_kbd_led_seq;

  localparam int T  = 20;
  localparam int MR = 2;

  localparam int R_ACK  = 0;
  localparam int R_NAK  = 1;
  localparam int R_NONE = 2;
  localparam int R_JUNK = 3;

  typedef struct {
    int code;
    int delay;
  } reply_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] leds = 3'b000;
  logic       tx_busy = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_wren;
  logic [7:0] tx_d;
  logic       busy;
  logic       error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  reply_t     rep_q[$];
  int         send_times[$];
  int         busy_fixed = 0;
  logic [2:0] model_last = 3'b000;
  logic       exp_err = 1'b0;
  logic [7:0] mon_exp;

  kbd_led_seq #(.ACK_TIMEOUT(T), .MAX_RETRY(MR)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .leds     (leds),
    .tx_busy  (tx_busy),
    .tx_wren  (tx_wren),
    .tx_d     (tx_d),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .error    (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reply choice for one transmitted byte.
  // policy 0 random, 1 ACK, 2 silent, 3 RESEND first command then ACK, 4 slow ACK
  function automatic reply_t pick(input int policy, input int ph, input int tries);
    reply_t r;
    int k;
    r.delay = $urandom_range(1, 5);
    r.code  = R_ACK;
    case (policy)
      1: r.code = R_ACK;
      2: r.code = R_NONE;
      3: r.code = (ph == 0 && tries == 0) ? R_NAK : R_ACK;
      4: r.delay = 5;
      default: begin
        k = $urandom_range(0, 9);
        if (k < 6)       r.code = R_ACK;
        else if (k == 6) r.code = R_NAK;
        else if (k == 7) r.code = R_NONE;
        else             r.code = R_JUNK;
      end
    endcase
    return r;
  endfunction

  // Protocol model: which bytes go out and whether the sequence aborts.
  task automatic model_seq(input logic [2:0] l, input int policy);
    logic [7:0] b;
    int         tries;
    bit         stop;
    reply_t     r;
    exp_err = 1'b0;
    stop = 1'b0;
    for (int ph = 0; ph < 2 && !stop; ph++) begin
      b = (ph == 0) ? 8'hED : {5'b00000, l};
      tries = 0;
      forever begin
        exp_q.push_back(b);
        r = pick(policy, ph, tries);
        rep_q.push_back(r);
        if (r.code == R_ACK || r.code == R_JUNK) break;
        if (tries == MR) begin
          exp_err = 1'b1;
          stop = 1'b1;
          break;
        end
        tries++;
      end
    end
    model_last = l;
  endtask

  // Scoreboard monitor: every send strobe is compared with the next expected byte.
  always @(negedge clk) begin
    if (reset_n && tx_wren) begin
      send_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_send actual=%0h required=none", tx_d);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_d", {24'd0, tx_d}, {24'd0, mon_exp});
      end
    end
  end

  // Transmitter and keyboard model.
  initial begin
    reply_t r;
    int     blen;
    @(negedge clk);
    forever begin
      if (reset_n && tx_wren) begin
        if (rep_q.size() > 0) r = rep_q.pop_front();
        else begin
          r.code = R_NONE;
          r.delay = 1;
        end
        blen = (busy_fixed != 0) ? 4 : $urandom_range(2, 6);
        @(negedge clk);
        tx_busy = 1'b1;
        // stray keyboard bytes while transmitting must be ignored
        if (busy_fixed == 0 && $urandom_range(0, 3) == 0) begin
          rx_valid = 1'b1;
          rx_data  = ($urandom_range(0, 1) == 0) ? 8'hFA : 8'hFE;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (blen - 1) @(negedge clk);
        tx_busy = 1'b0;
        if (r.code != R_NONE) begin
          repeat (r.delay) @(negedge clk);
          if (r.code == R_JUNK) begin
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            @(negedge clk);
            rx_valid = 1'b0;
            @(negedge clk);
          end
          rx_valid = 1'b1;
          rx_data  = (r.code == R_NAK) ? 8'hFE : 8'hFA;
          @(negedge clk);
          rx_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy && !tx_busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      failures++;
      $display("FAIL %s_timeout actual=pending%0d required=done", name, exp_q.size());
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_sends(input int target, input string name);
    int n;
    n = 0;
    while (send_times.size() < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL %s_wait actual=%0d required=%0d", name, send_times.size(), target);
    end
  endtask

  task automatic wait_txbusy(input logic level);
    int n;
    n = 0;
    while (tx_busy !== level && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL tx_busy_wait actual=%0b required=%0b", tx_busy, level);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [2:0] l;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_wren", {31'd0, tx_wren}, 32'd0);
    check("rst_tx_d",    {24'd0, tx_d},    32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_error",   {31'd0, error},   32'd0);

    model_last = 3'b000;
`ifdef KBD_LED_INIT_SEND_EN
    model_seq(3'b000, 1);
`endif
    reset_n = 1'b1;
`ifdef KBD_LED_INIT_SEND_EN
    wait_done("init");
    check("init_error", {31'd0, error}, 32'd0);
`endif
    repeat (20) @(negedge clk);

    // 000 -> 100 with every byte acknowledged
    s0 = send_times.size();
    model_seq(3'b100, 1);
    leds = 3'b100;
    wait_done("basic");
    check("basic_error", {31'd0, error}, 32'd0);
    check("basic_busy",  {31'd0, busy},  32'd0);
    check("basic_sends", send_times.size() - s0, 2);

    // first command reply is RESEND
    s0 = send_times.size();
    model_seq(3'b001, 3);
    leds = 3'b001;
    wait_done("resend");
    check("resend_error", {31'd0, error}, 32'd0);
    check("resend_sends", send_times.size() - s0, 3);

    // silent keyboard: three commands spaced by the reply timeout, then abort
    busy_fixed = 1;
    s0 = send_times.size();
    model_seq(3'b011, 2);
    leds = 3'b011;
    wait_done("silent");
    busy_fixed = 0;
    check("silent_error", {31'd0, error}, 32'd1);
    check("silent_sends", send_times.size() - s0, 3);
    check("silent_gap1", send_times[s0 + 1] - send_times[s0], T + 4 + 3);
    check("silent_gap2", send_times[s0 + 2] - send_times[s0 + 1], T + 4 + 3);
    s0 = send_times.size();
    repeat (40) @(negedge clk);
    check("silent_no_retrigger", send_times.size() - s0, 0);
    check("silent_idle_busy", {31'd0, busy}, 32'd0);

    // leds changes while the argument byte awaits its reply
    s0 = send_times.size();
    model_seq(3'b100, 4);
    model_seq(3'b010, 1);
    leds = 3'b100;
    wait_sends(s0 + 2, "late_change");
    wait_txbusy(1'b1);
    wait_txbusy(1'b0);
    @(negedge clk);
    leds = 3'b010;
    wait_done("late_change");
    check("late_change_error", {31'd0, error}, 32'd0);
    check("late_change_sends", send_times.size() - s0, 4);

    // randomized LED updates against a randomly behaving keyboard
    for (int i = 0; i < 12; i++) begin
      l = 3'($urandom_range(0, 7));
      if (l == model_last) l = l ^ 3'b110;
      model_seq(l, 0);
      leds = l;
      wait_done("random");
      check("random_error", {31'd0, error}, {31'd0, exp_err});
      check("random_busy",  {31'd0, busy},  32'd0);
    end

    // reset while waiting for the transmitter to finish
    l = model_last ^ 3'b101;
    model_seq(l, 1);
    s0 = send_times.size();
    leds = l;
    wait_sends(s0 + 1, "reset_mid");
    wait_txbusy(1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx_wren", {31'd0, tx_wren}, 32'd0);
    check("mid_rst_tx_d",    {24'd0, tx_d},    32'd0);
    check("mid_rst_busy",    {31'd0, busy},    32'd0);
    check("mid_rst_error",   {31'd0, error},   32'd0);
    leds = 3'b000;
    repeat (40) @(negedge clk);
    exp_q.delete();
    rep_q.delete();
    model_last = 3'b000;
`ifdef KBD_LED_INIT_SEND_EN
    model_seq(3'b000, 1);
`endif
    s0 = send_times.size();
    reset_n = 1'b1;
`ifdef KBD_LED_INIT_SEND_EN
    wait_done("post_reset");
    check("post_reset_sends", send_times.size() - s0, 2);
`else
    repeat (40) @(negedge clk);
    check("post_reset_sends", send_times.size() - s0, 0);
`endif
    check("post_reset_error", {31'd0, error}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
